mem_rr_arbiter: RTL and testbench

MEM_RR_ARBITER -- requirements
Module: mem_rr_arbiter

---
 rtl/mem_pkg.sv | 24 ++
 rtl/mem_rr_arbiter_queue.sv | 60 ++++++
 rtl/mem_rr_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_rr_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the memory round-robin arbiter: master index, arbiter state,
// and the round-robin pointer advance helper.
package mem_pkg;

  // Index width covers the largest supported master count, so one type serves every CNT.
  localparam int MAX_MASTERS = 16;

  typedef logic [$clog2(MAX_MASTERS)-1:0] master_idx_t;
  typedef logic [MAX_MASTERS-1:0]         master_mask_t;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  function automatic master_idx_t next_idx(input master_idx_t idx, input int cnt);
    if (idx == master_idx_t'(cnt - 1)) begin
      return master_idx_t'(1'b0);
    end else begin
      return idx + master_idx_t'(1'b1);
    end
  endfunction

endpackage

// File: rtl/mem_rr_arbiter_queue.sv
// Small synchronous FIFO; full/empty come from registered occupancy only, so a
// same-cycle pop never frees a slot for a same-cycle push.
module mem_rr_arbiter_queue #(
  parameter type data_t = logic,
  parameter int  DEPTH  = 8
) (
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  logic  i_push,
  input  data_t i_push_data,
  input  logic  i_pop,
  output data_t o_head,
  output logic  o_empty,
  output logic  o_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;
  localparam ptr_t LAST = ptr_t'(DEPTH - 1);

  data_t r_mem [DEPTH];
  ptr_t  r_wr_ptr;
  ptr_t  r_rd_ptr;
  cnt_t  r_count;
  logic  w_push;
  logic  w_pop;

  assign o_empty = (r_count == cnt_t'(1'b0));
  assign o_full  = (r_count == cnt_t'(DEPTH));
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage, pointers and occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= data_t'(1'b0);
      end
      r_wr_ptr <= ptr_t'(1'b0);
      r_rd_ptr <= ptr_t'(1'b0);
      r_count  <= cnt_t'(1'b0);
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= (r_wr_ptr == LAST) ? ptr_t'(1'b0) : r_wr_ptr + ptr_t'(1'b1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST) ? ptr_t'(1'b0) : r_rd_ptr + ptr_t'(1'b1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + cnt_t'(1'b1);
        2'b01:   r_count <= r_count - cnt_t'(1'b1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter from CNT masters onto one memory slave, with in-order
// response routing through a queue of granted master indices.
module mem_rr_arbiter
  import mem_pkg::*;
#(
  parameter int CNT         = 4,
  parameter int REQ_WIDTH   = 96,
  parameter int RESP_WIDTH  = 64,
  parameter int QUEUE_DEPTH = 8,
  parameter int MAX_OUT     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CNT-1:0]           master_req_valid,
  output logic [CNT-1:0]           master_req_ready,
  input  logic [CNT*REQ_WIDTH-1:0] master_req_data,
  output logic [CNT-1:0]           master_resp_valid,
  input  logic [CNT-1:0]           master_resp_ready,
  output logic [RESP_WIDTH-1:0]    master_resp_data,
  output logic                     slave_req_valid,
  input  logic                     slave_req_ready,
  output logic [REQ_WIDTH-1:0]     slave_req_data,
  input  logic                     slave_resp_valid,
  output logic                     slave_resp_ready,
  input  logic [RESP_WIDTH-1:0]    slave_resp_data,
  output logic                     err
);

  localparam int OCW = $clog2(MAX_OUT + 1);
  typedef logic [OCW-1:0] ocnt_t;
  localparam ocnt_t CAP = ocnt_t'(MAX_OUT);

  arb_state_t   r_state;
  arb_state_t   w_state_nxt;
  master_idx_t  r_rr_ptr;
  master_idx_t  r_lock_idx;
  ocnt_t        r_out_cnt [MAX_MASTERS];
  logic         r_err;

  master_mask_t w_valid_x;
  master_mask_t w_rdy_x;
  master_mask_t w_elig;
  logic         w_rr_hit;
  master_idx_t  w_rr_idx;
  logic         w_grant_vld;
  master_idx_t  w_grant_idx;
  logic         w_drop;
  logic         w_req_fire;
  logic         w_rsp_route;
  logic         w_rsp_fire;
  master_idx_t  w_q_head;
  logic         w_q_empty;
  logic         w_q_full;

  assign w_valid_x = master_mask_t'(master_req_valid);
  assign w_rdy_x   = master_mask_t'(master_resp_ready);

  // Eligibility; rst gates it so nothing is offered while reset is asserted.
  always_comb begin
    w_elig = master_mask_t'(1'b0);
    for (int i = 0; i < MAX_MASTERS; i++) begin
      w_elig[i] = rst && w_valid_x[i] && (r_out_cnt[i] < CAP) && !w_q_full;
    end
  end

  // Round-robin search starting at r_rr_ptr, first eligible master wins.
  always_comb begin
    master_idx_t w_cand;
    w_rr_hit = 1'b0;
    w_rr_idx = master_idx_t'(1'b0);
    w_cand   = master_idx_t'(1'b0);
    for (int k = 0; k < CNT; k++) begin
      w_cand   = master_idx_t'((int'(r_rr_ptr) + k) % CNT);
      w_rr_idx = (!w_rr_hit && w_elig[w_cand]) ? w_cand : w_rr_idx;
      w_rr_hit = w_rr_hit | w_elig[w_cand];
    end
  end

  // Grant selection and lock state transitions.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_vld = 1'b0;
    w_grant_idx = master_idx_t'(1'b0);
    w_drop      = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        w_grant_vld = w_rr_hit;
        w_grant_idx = w_rr_idx;
        w_state_nxt = (w_rr_hit && !slave_req_ready) ? ARB_LOCKED : ARB_IDLE;
      end
      ARB_LOCKED: begin
        w_grant_idx = r_lock_idx;
        w_grant_vld = rst && w_valid_x[r_lock_idx];
        w_drop      = rst && !w_valid_x[r_lock_idx];
        w_state_nxt = (slave_req_ready || w_drop) ? ARB_IDLE : ARB_LOCKED;
      end
      default: begin
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

  assign w_req_fire  = w_grant_vld && slave_req_ready;
  assign w_rsp_route = rst && !w_q_empty;
  assign w_rsp_fire  = slave_resp_valid && slave_resp_ready;

  assign slave_req_valid  = w_grant_vld;
  assign slave_req_data   = master_req_data[w_grant_idx*REQ_WIDTH +: REQ_WIDTH];
  assign slave_resp_ready = w_rsp_route && w_rdy_x[w_q_head];
  assign master_resp_data = slave_resp_data;
  assign err              = r_err;

  // Per-master handshake decode from the current grant and the queue head.
  always_comb begin
    master_req_ready  = '0;
    master_resp_valid = '0;
    for (int i = 0; i < CNT; i++) begin
      master_req_ready[i]  = w_req_fire && (w_grant_idx == master_idx_t'(i));
      master_resp_valid[i] = w_rsp_route && slave_resp_valid && (w_q_head == master_idx_t'(i));
    end
  end

  mem_rr_arbiter_queue #(
    .data_t (master_idx_t),
    .DEPTH  (QUEUE_DEPTH)
  ) u_route_q (
    .i_clk       (clk),
    .i_rst_n     (rst),
    .i_push      (w_req_fire),
    .i_push_data (w_grant_idx),
    .i_pop       (w_rsp_fire),
    .o_head      (w_q_head),
    .o_empty     (w_q_empty),
    .o_full      (w_q_full)
  );

  // Arbiter state, pointer, lock owner and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ARB_IDLE;
      r_rr_ptr   <= master_idx_t'(1'b0);
      r_lock_idx <= master_idx_t'(1'b0);
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_req_fire ? next_idx(w_grant_idx, CNT) : r_rr_ptr;
      r_lock_idx <= (w_state_nxt == ARB_LOCKED) ? w_grant_idx : r_lock_idx;
      if ((slave_resp_valid && w_q_empty) || w_drop) begin
        r_err <= 1'b1;
      end else begin
        r_err <= r_err;
      end
    end
  end

  // Outstanding counters; a same-cycle issue and completion cancel out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MAX_MASTERS; i++) begin
        r_out_cnt[i] <= ocnt_t'(1'b0);
      end
    end else begin
      for (int i = 0; i < MAX_MASTERS; i++) begin
        case ({w_req_fire && (w_grant_idx == master_idx_t'(i)),
               w_rsp_fire && (w_q_head == master_idx_t'(i))})
          2'b10:   r_out_cnt[i] <= r_out_cnt[i] + ocnt_t'(1'b1);
          2'b01:   r_out_cnt[i] <= r_out_cnt[i] - ocnt_t'(1'b1);
          default: r_out_cnt[i] <= r_out_cnt[i];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Self-checking bench for mem_rr_arbiter: directed scenarios plus a randomized
// run, all compared every cycle against a queue-based reference model.
module tb_mem_rr_arbiter;

  localparam int CNT = 4;
  localparam int RW  = 96;
  localparam int SW  = 64;
  localparam int QD  = 8;
  localparam int MO  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [CNT-1:0]    mv;
  logic [RW-1:0]     md [CNT];
  logic [CNT*RW-1:0] md_flat;
  logic [CNT-1:0]    mrsp_rdy;
  logic              sreq_rdy;
  logic              srsp_vld;
  logic [SW-1:0]     srsp_data;

  logic [CNT-1:0]    master_req_ready;
  logic [CNT-1:0]    master_resp_valid;
  logic [SW-1:0]     master_resp_data;
  logic              slave_req_valid;
  logic [RW-1:0]     slave_req_data;
  logic              slave_resp_ready;
  logic              err;

  assign md_flat = {md[3], md[2], md[1], md[0]};

  mem_rr_arbiter #(
    .CNT(CNT), .REQ_WIDTH(RW), .RESP_WIDTH(SW), .QUEUE_DEPTH(QD), .MAX_OUT(MO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .master_req_valid (mv),
    .master_req_ready (master_req_ready),
    .master_req_data  (md_flat),
    .master_resp_valid(master_resp_valid),
    .master_resp_ready(mrsp_rdy),
    .master_resp_data (master_resp_data),
    .slave_req_valid  (slave_req_valid),
    .slave_req_ready  (sreq_rdy),
    .slave_req_data   (slave_req_data),
    .slave_resp_valid (srsp_vld),
    .slave_resp_ready (slave_resp_ready),
    .slave_resp_data  (srsp_data),
    .err              (err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pointer, lock owner, per-master outstanding counts, route queue.
  int             m_ptr;
  int             m_lock;
  bit             m_locked;
  bit             m_err;
  int             m_cnt [CNT];
  int             m_q [$];
  bit             e_gv;
  bit             e_drop;
  int             e_gi;
  logic [CNT-1:0] fired;
  int             g034 [5] = '{0, 1, 2, 3, 0};

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] rnd96();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  function automatic void model_reset();
    m_ptr = 0; m_lock = 0; m_locked = 1'b0; m_err = 1'b0;
    for (int i = 0; i < CNT; i++) m_cnt[i] = 0;
    m_q.delete();
  endfunction

  function automatic void model_eval();
    e_gv = 1'b0; e_gi = 0; e_drop = 1'b0;
    if (m_locked) begin
      if (mv[m_lock]) begin e_gv = 1'b1; e_gi = m_lock; end
      else e_drop = 1'b1;
    end else begin
      for (int k = 0; k < CNT; k++) begin
        int j;
        j = (m_ptr + k) % CNT;
        if (!e_gv && mv[j] && m_cnt[j] < MO && m_q.size() < QD) begin
          e_gv = 1'b1; e_gi = j;
        end
      end
    end
  endfunction

  function automatic void model_step();
    bit had;
    int head;
    bit rsp_fire;
    model_eval();
    had      = (m_q.size() > 0);
    head     = had ? m_q[0] : 0;
    rsp_fire = had && srsp_vld && mrsp_rdy[head];
    if (!had && srsp_vld) m_err = 1'b1;
    if (e_drop) begin
      m_err = 1'b1; m_locked = 1'b0;
    end else if (e_gv && sreq_rdy) begin
      m_ptr = (e_gi + 1) % CNT; m_locked = 1'b0;
      m_cnt[e_gi]++; m_q.push_back(e_gi); fired[e_gi] = 1'b1;
    end else if (e_gv) begin
      m_locked = 1'b1; m_lock = e_gi;
    end
    if (rsp_fire) begin
      void'(m_q.pop_front());
      m_cnt[head]--;
    end
  endfunction

  task automatic tick_check();
    logic [CNT-1:0] exp_mrv;
    logic           exp_srr;
    #1;
    model_eval();
    exp_mrv = '0;
    exp_srr = 1'b0;
    if (m_q.size() > 0) begin
      exp_mrv = srsp_vld ? (CNT'(1) << m_q[0]) : '0;
      exp_srr = mrsp_rdy[m_q[0]];
    end
    check_eq("sreq_valid", slave_req_valid, e_gv);
    if (e_gv) check_eq("sreq_data", slave_req_data, md[e_gi]);
    check_eq("mreq_ready", master_req_ready, (e_gv && sreq_rdy) ? (CNT'(1) << e_gi) : '0);
    check_eq("mresp_valid", master_resp_valid, exp_mrv);
    check_eq("sresp_ready", slave_resp_ready, exp_srr);
    check_eq("mresp_data", master_resp_data, srsp_data);
    check_eq("err", err, m_err);
  endtask

  task automatic tick_adv();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic tick();
    tick_check();
    tick_adv();
  endtask

  task automatic idle_inputs();
    mv = '0; sreq_rdy = 1'b0; srsp_vld = 1'b0; mrsp_rdy = '0;
    srsp_data = {$urandom(), $urandom()};
  endtask

  // Entered on a negedge; busy inputs make the output gating observable.
  task automatic do_reset();
    rst = 1'b0; mv = '1; sreq_rdy = 1'b1; srsp_vld = 1'b1; mrsp_rdy = '1;
    #1;
    check_eq("rst_sreq_valid", slave_req_valid, 1'b0);
    check_eq("rst_mreq_ready", master_req_ready, 4'b0000);
    check_eq("rst_mresp_valid", master_resp_valid, 4'b0000);
    check_eq("rst_sresp_ready", slave_resp_ready, 1'b0);
    check_eq("rst_err", err, 1'b0);
    @(posedge clk);
    @(negedge clk);
    model_reset();
    idle_inputs();
    fired = '0;
    rst = 1'b1;
  endtask

  task automatic drive_random(input int c);
    for (int i = 0; i < CNT; i++) begin
      if (!mv[i] || fired[i]) begin
        mv[i] = ($urandom_range(0, 2) != 0);
        md[i] = rnd96();
      end
    end
    fired     = '0;
    sreq_rdy  = ($urandom_range(0, 3) != 0);
    srsp_vld  = (m_q.size() > 0) && ($urandom_range(0, 9) < ((((c / 150) % 2) != 0) ? 2 : 8));
    mrsp_rdy  = 4'($urandom());
    srsp_data = {$urandom(), $urandom()};
  endtask

  initial begin
    rst = 1'b0;
    fired = '0;
    for (int i = 0; i < CNT; i++) md[i] = rnd96();
    idle_inputs();
    model_reset();
    @(negedge clk);

    // All masters valid, slave always ready: grants rotate 0,1,2,3,0.
    do_reset();
    mv = '1; sreq_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick_check();
      check_eq("t034_grant", master_req_ready, CNT'(1) << g034[k]);
      tick_adv();
    end

    // Lock on master 2 for three stalled cycles, then rotate on to master 3.
    do_reset();
    sreq_rdy = 1'b1; mv = 4'b0010;
    tick();
    mv = 4'b1101; sreq_rdy = 1'b0;
    repeat (3) begin
      tick_check();
      check_eq("t035_hold_valid", slave_req_valid, 1'b1);
      check_eq("t035_hold_data", slave_req_data, md[2]);
      tick_adv();
    end
    sreq_rdy = 1'b1;
    tick_check();
    check_eq("t035_fire", master_req_ready, 4'b0100);
    tick_adv();
    mv[2] = 1'b0;
    tick_check();
    check_eq("t035_next", master_req_ready, 4'b1000);
    tick_adv();

    // Outstanding cap: two issues block master 1 until one response returns.
    do_reset();
    sreq_rdy = 1'b1; mv = 4'b0010;
    tick();
    tick();
    tick_check();
    check_eq("t036_capped", slave_req_valid, 1'b0);
    tick_adv();
    srsp_vld = 1'b1; mrsp_rdy = '1;
    tick_check();
    check_eq("t036_capped_resp", slave_req_valid, 1'b0);
    check_eq("t036_resp_route", master_resp_valid, 4'b0010);
    tick_adv();
    srsp_vld = 1'b0;
    tick_check();
    check_eq("t036_reeligible", master_req_ready, 4'b0010);
    tick_adv();

    // In-order routing for issue order 3,0,3 with master 0 stalling.
    do_reset();
    sreq_rdy = 1'b1;
    mv = 4'b1000; tick();
    mv = 4'b0001; tick();
    mv = 4'b1000; tick();
    mv = '0; sreq_rdy = 1'b0;
    srsp_vld = 1'b1; mrsp_rdy = '1; srsp_data = 64'h0000_0000_0000_00AA;
    tick_check();
    check_eq("t037_a_route", master_resp_valid, 4'b1000);
    check_eq("t037_a_data", master_resp_data, 64'h0000_0000_0000_00AA);
    tick_adv();
    srsp_data = 64'h0000_0000_0000_00BB; mrsp_rdy = 4'b1110;
    repeat (2) begin
      tick_check();
      check_eq("t037_b_route", master_resp_valid, 4'b0001);
      check_eq("t037_b_stall", slave_resp_ready, 1'b0);
      tick_adv();
    end
    mrsp_rdy = '1;
    tick_check();
    check_eq("t037_b_fire", slave_resp_ready, 1'b1);
    tick_adv();
    srsp_data = 64'h0000_0000_0000_00CC;
    tick_check();
    check_eq("t037_c_route", master_resp_valid, 4'b1000);
    tick_adv();
    srsp_vld = 1'b0;
    tick();

    // Response with empty route queue sets a sticky error.
    do_reset();
    srsp_vld = 1'b1;
    tick_check();
    check_eq("t038_empty_rdy", slave_resp_ready, 1'b0);
    tick_adv();
    srsp_vld = 1'b0;
    repeat (3) begin
      tick_check();
      check_eq("t038_err_sticky", err, 1'b1);
      tick_adv();
    end

    // Reset mid-lock clears outputs and pointer; the dropped request's late response errs.
    do_reset();
    sreq_rdy = 1'b1; mv = 4'b0100;
    tick();
    mv = 4'b0010; sreq_rdy = 1'b0;
    tick();
    tick_check();
    check_eq("t038_locked", slave_req_data, md[1]);
    tick_adv();
    do_reset();
    srsp_vld = 1'b1; sreq_rdy = 1'b1; mv = 4'b1010;
    tick_check();
    check_eq("t038_ptr_reset", master_req_ready, 4'b0010);
    tick_adv();
    srsp_vld = 1'b0; mv = '0;
    tick_check();
    check_eq("t038_late_resp_err", err, 1'b1);
    tick_adv();

    // Locked master dropping valid: nothing issues, error follows.
    do_reset();
    mv = 4'b0010; sreq_rdy = 1'b0;
    tick();
    mv = '0; sreq_rdy = 1'b1;
    tick_check();
    check_eq("t028_no_issue", slave_req_valid, 1'b0);
    check_eq("t028_err_pending", err, 1'b0);
    tick_adv();
    tick_check();
    check_eq("t028_err", err, 1'b1);
    tick_adv();

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      drive_random(c);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
